// File: rtl/cpu_pkg.sv
// Shared types and constants for the MEM pipeline stage.
// Holds the memory-access FSM state encoding and datapath widths.
package cpu_pkg;

    localparam int DATA_W          = 16;
    localparam int REG_W           = 4;
    localparam int CNT_W           = 4;
    localparam int TIMEOUT_DEFAULT = 15;

    localparam logic [DATA_W-1:0] ERR_DATA = 16'hDEAD;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and memory.
// The stage drives the request side; memory answers with rdata/ack.
interface mem_stage_if;
    import cpu_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );

endinterface

// File: rtl/mem_ctrl_fsm.sv
// IDLE/WAIT/DONE sequencer for one data-memory access.
// Optional MEM_TIMEOUT_EN adds a WAIT-cycle counter and sticky error.
module mem_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_access,
    input  logic i_ack,
    output logic o_idle,
    output logic o_wait,
    output logic o_done,
    output logic o_capture,
    output logic o_timeout,
    output logic o_err
);

    mem_state_t r_state;
    mem_state_t w_next;
    logic       w_expire;

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    // WAIT-cycle counter, restarted whenever a new access enters WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == IDLE && i_access) begin
            r_cnt <= '0;
        end else if (r_state == WAIT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Sticky error flag, only cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (o_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign w_expire = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign o_err    = r_err;
`else
    logic w_unused_tc;

    assign w_unused_tc = (TIMEOUT_CYCLES != 0);
    assign w_expire    = 1'b0;
    assign o_err       = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: ack only matters in WAIT, DONE lasts one cycle
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (i_access) w_next = WAIT;
            WAIT:    if (i_ack || w_expire) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State decodes and completion strobes for the datapath
    always_comb begin
        o_idle    = (r_state == IDLE);
        o_wait    = (r_state == WAIT);
        o_done    = (r_state == DONE);
        o_capture = o_wait & i_ack;
        o_timeout = o_wait & ~i_ack & w_expire;
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory accesses, stalls the front end
// until completion, and forwards results to MEM/WB. Option: MEM_TIMEOUT_EN.
module mem_stage
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              regwrite,
    input  logic              memtoreg,
    input  logic              branch,
    input  logic              memwrite,
    input  logic              memread,
    input  logic [DATA_W-1:0] addresult,
    input  logic [DATA_W-1:0] aluresult,
    input  logic [DATA_W-1:0] regread2,
    input  logic              zeroflag,
    input  logic [REG_W-1:0]  muxout,
    mem_stage_if.master       mem,
    output logic              stall,
    output logic              pcsrc,
    output logic [DATA_W-1:0] branch_target,
    output logic              wb_wen,
    output logic              wb_regwrite,
    output logic              wb_memtoreg,
    output logic [DATA_W-1:0] wb_readdata,
    output logic [DATA_W-1:0] wb_aluresult,
    output logic [REG_W-1:0]  wb_dest,
    output logic              mem_err
);

    logic              w_access;
    logic              w_load;
    logic              w_idle;
    logic              w_wait;
    logic              w_done;
    logic              w_capture;
    logic              w_timeout;
    logic              w_err;
    logic [DATA_W-1:0] r_rdata;

    // A simultaneous read+write is treated as a plain write
    assign w_access = memread | memwrite;
    assign w_load   = memread & ~memwrite;

    mem_ctrl_fsm #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .i_access  (w_access),
        .i_ack     (mem.mem_ack),
        .o_idle    (w_idle),
        .o_wait    (w_wait),
        .o_done    (w_done),
        .o_capture (w_capture),
        .o_timeout (w_timeout),
        .o_err     (w_err)
    );

    // Load data register; timed-out accesses return the error pattern
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (w_capture && w_load) begin
            r_rdata <= mem.mem_rdata;
        end else if (w_timeout) begin
            r_rdata <= ERR_DATA;
        end
    end

    // Request, stall and branch gating; reset masks everything at once
    always_comb begin
        mem.mem_req   = ((w_idle & w_access) | w_wait) & ~rst;
        mem.mem_we    = mem.mem_req & memwrite;
        mem.mem_addr  = aluresult;
        mem.mem_wdata = regread2;
        stall         = w_access & ~w_done & ~rst;
        wb_wen        = ~stall;
        pcsrc         = branch & zeroflag & ~stall & ~rst;
        branch_target = addresult;
    end

    // Straight-through forwarding to MEM/WB
    always_comb begin
        wb_regwrite  = regwrite;
        wb_memtoreg  = memtoreg;
        wb_aluresult = aluresult;
        wb_dest      = muxout;
        wb_readdata  = r_rdata;
        mem_err      = w_err;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: random and directed instructions,
// a reactive memory model, and a monitor that checks each completion.
module tb_mem_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        regwrite, memtoreg, branch, memwrite, memread, zeroflag;
    logic [15:0] addresult, aluresult, regread2;
    logic [3:0]  muxout;
    logic        stall, pcsrc, wb_wen, wb_regwrite, wb_memtoreg, mem_err;
    logic [15:0] branch_target, wb_readdata, wb_aluresult;
    logic [3:0]  wb_dest;

    mem_stage_if mif ();

    mem_stage dut (
        .clk           (clk),
        .rst           (rst),
        .regwrite      (regwrite),
        .memtoreg      (memtoreg),
        .branch        (branch),
        .memwrite      (memwrite),
        .memread       (memread),
        .addresult     (addresult),
        .aluresult     (aluresult),
        .regread2      (regread2),
        .zeroflag      (zeroflag),
        .muxout        (muxout),
        .mem           (mif),
        .stall         (stall),
        .pcsrc         (pcsrc),
        .branch_target (branch_target),
        .wb_wen        (wb_wen),
        .wb_regwrite   (wb_regwrite),
        .wb_memtoreg   (wb_memtoreg),
        .wb_readdata   (wb_readdata),
        .wb_aluresult  (wb_aluresult),
        .wb_dest       (wb_dest),
        .mem_err       (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        store;
        int          stall_n;
        logic [15:0] rdata;
        logic [15:0] alu;
        logic [15:0] wdata;
        logic [15:0] tgt;
        logic [3:0]  dest;
        logic        rw;
        logic        m2r;
        logic        pc;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] model_rdata = 16'h0;
    int          ack_delay = 1;
    logic [15:0] ack_data = 16'h0;
    bit          resp_en = 1'b0;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Memory model: acks on the chosen WAIT cycle, random ack elsewhere
    initial begin
        int rc;
        rc = 0;
        mif.mem_ack = 1'b0;
        mif.mem_rdata = 16'h0;
        forever begin
            @(negedge clk);
            if (resp_en) begin
                if (mif.mem_req) begin
                    rc++;
                    if (rc == 1) mif.mem_ack = 1'($urandom_range(0, 1));
                    else mif.mem_ack = (rc == ack_delay + 1);
                    mif.mem_rdata = (mif.mem_ack && rc > 1) ? ack_data
                                                            : 16'($urandom);
                end else begin
                    rc = 0;
                    mif.mem_ack = 1'($urandom_range(0, 1));
                    mif.mem_rdata = 16'($urandom);
                end
            end else begin
                rc = 0;
            end
        end
    end

    // Monitor: per-cycle bus checks, full check when MEM/WB is written
    initial begin
        int   sc;
        int   rc;
        exp_t h;
        sc = 0;
        rc = 0;
        forever begin
            @(negedge clk);
            if (mon_en && q.size() > 0) begin
                h = q[0];
                if (mif.mem_req) begin
                    rc++;
                    chk("mem_we", 32'(mif.mem_we), 32'(h.store));
                    chk("mem_addr", 32'(mif.mem_addr), 32'(h.alu));
                    chk("mem_wdata", 32'(mif.mem_wdata), 32'(h.wdata));
                end
                if (stall) begin
                    sc++;
                    chk("pcsrc_in_stall", 32'(pcsrc), 32'd0);
                end
                if (wb_wen) begin
                    void'(q.pop_front());
                    chk("stall_cycles", 32'(sc), 32'(h.stall_n));
                    chk("req_cycles", 32'(rc), 32'(h.stall_n));
                    chk("wb_readdata", 32'(wb_readdata), 32'(h.rdata));
                    chk("wb_aluresult", 32'(wb_aluresult), 32'(h.alu));
                    chk("wb_dest", 32'(wb_dest), 32'(h.dest));
                    chk("wb_regwrite", 32'(wb_regwrite), 32'(h.rw));
                    chk("wb_memtoreg", 32'(wb_memtoreg), 32'(h.m2r));
                    chk("pcsrc", 32'(pcsrc), 32'(h.pc));
                    chk("branch_target", 32'(branch_target), 32'(h.tgt));
                    sc = 0;
                    rc = 0;
                end
            end
        end
    end

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    // Present one instruction, push its expected result, hold until done
    task automatic issue(input logic rd, input logic wr, input logic br,
                         input logic z, input logic [15:0] alu,
                         input logic [15:0] wd, input logic [15:0] tgt,
                         input logic [3:0] dst, input logic rw,
                         input logic m2r, input int d,
                         input logic [15:0] rdat);
        exp_t e;
        int   n;
        memread = rd;
        memwrite = wr;
        branch = br;
        zeroflag = z;
        aluresult = alu;
        regread2 = wd;
        addresult = tgt;
        muxout = dst;
        regwrite = rw;
        memtoreg = m2r;
        ack_delay = d;
        ack_data = rdat;
        if (rd && !wr) model_rdata = rdat;
        e.store = wr;
        e.stall_n = (rd || wr) ? 1 + d : 0;
        e.rdata = model_rdata;
        e.alu = alu;
        e.wdata = wd;
        e.tgt = tgt;
        e.dest = dst;
        e.rw = rw;
        e.m2r = m2r;
        e.pc = br & z;
        q.push_back(e);
        n = 0;
        @(negedge clk);
        while (stall && n < 64) begin
            n++;
            @(negedge clk);
        end
        if (n >= 64) begin
            errors++;
            checks++;
            $display("FAIL stall_stuck: got stall=1 after %0d cycles", n);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $fatal(1, "stall never released");
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic rd, wr;
        rst = 1'b1;
        memread = 1'b1;
        memwrite = 1'b0;
        branch = 1'b1;
        zeroflag = 1'b1;
        regwrite = 1'b0;
        memtoreg = 1'b0;
        addresult = 16'h0;
        aluresult = 16'h0;
        regread2 = 16'h0;
        muxout = 4'h0;
        repeat (2) @(negedge clk);
        chk("rst_mem_req", 32'(mif.mem_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_pcsrc", 32'(pcsrc), 32'd0);
        chk("rst_rdata", 32'(wb_readdata), 32'd0);
        chk("rst_mem_err", 32'(mem_err), 32'd0);
        memread = 1'b0;
        branch = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        resp_en = 1'b1;
        mon_en = 1'b1;

        // ALU op, load with one WAIT, store with four WAITs, branches
        issue(0, 0, 0, 0, 16'h1234, 16'h0, 16'h0, 4'h3, 1, 0, 0, 16'h0);
        issue(1, 0, 0, 0, 16'h0040, 16'h0, 16'h0, 4'h5, 1, 1, 1, 16'hBEEF);
        issue(0, 1, 0, 0, 16'h0010, 16'h5555, 16'h0, 4'h0, 0, 0, 4,
              16'h7777);
        issue(0, 0, 1, 1, 16'h0, 16'h0, 16'h0100, 4'h0, 0, 0, 0, 16'h0);
        issue(0, 0, 1, 0, 16'h0, 16'h0, 16'h0100, 4'h0, 0, 0, 0, 16'h0);
        issue(1, 1, 0, 0, 16'h0022, 16'hA5A5, 16'h0, 4'h1, 0, 0, 2,
              16'h1111);

        for (int i = 0; i < 150; i++) begin
            rd = ($urandom_range(0, 2) == 0);
            wr = ($urandom_range(0, 2) == 0);
            issue(rd, wr, 1'($urandom), 1'($urandom), 16'($urandom),
                  16'($urandom), 16'($urandom), 4'($urandom),
                  1'($urandom), 1'($urandom), $urandom_range(1, 6),
                  16'($urandom));
        end
        chk("no_err_yet", 32'(mem_err), 32'd0);

        // Reset in the middle of WAIT abandons the access
        mon_en = 1'b0;
        resp_en = 1'b0;
        mif.mem_ack = 1'b0;
        memread = 1'b1;
        memwrite = 1'b0;
        branch = 1'b1;
        zeroflag = 1'b1;
        aluresult = 16'h0080;
        repeat (3) @(posedge clk);
        #2;
        chk("wait_req", 32'(mif.mem_req), 32'd1);
        chk("wait_stall", 32'(stall), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_req", 32'(mif.mem_req), 32'd0);
        chk("async_stall", 32'(stall), 32'd0);
        chk("async_pcsrc", 32'(pcsrc), 32'd0);
        chk("async_rdata", 32'(wb_readdata), 32'd0);
        memread = 1'b0;
        branch = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mif.mem_ack = 1'b1;
        mif.mem_rdata = 16'hFFFF;
        @(posedge clk);
        #1;
        mif.mem_ack = 1'b0;
        chk("post_rst_rdata", 32'(wb_readdata), 32'd0);
        chk("post_rst_stall", 32'(stall), 32'd0);
        chk("post_rst_req", 32'(mif.mem_req), 32'd0);
        model_rdata = 16'h0;
        resp_en = 1'b1;
        mon_en = 1'b1;
        issue(0, 0, 0, 0, 16'h4321, 16'h0, 16'h0, 4'h9, 1, 0, 0, 16'h0);
        issue(1, 0, 0, 0, 16'h0044, 16'h0, 16'h0, 4'h2, 1, 1, 3, 16'hC0DE);

`ifdef MEM_TIMEOUT_EN
        // No ack at all: abort after the WAIT budget with error data
        resp_en = 1'b0;
        mif.mem_ack = 1'b0;
        issue(1, 0, 0, 0, 16'h0050, 16'h0, 16'h0, 4'h4, 1, 1, 15, 16'hDEAD);
        chk("timeout_err", 32'(mem_err), 32'd1);
        resp_en = 1'b1;
        issue(0, 0, 0, 0, 16'h0001, 16'h0, 16'h0, 4'h1, 1, 0, 0, 16'h0);
        chk("err_sticky", 32'(mem_err), 32'd1);
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("err_cleared", 32'(mem_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
`else
        chk("err_tied", 32'(mem_err), 32'd0);
`endif
        repeat (2) @(posedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        finish_run();
    end

    initial begin
        #400000;
        errors++;
        checks++;
        $display("FAIL global_timeout: run did not complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 15, maximum WAIT cycles before abort (used only under MEM_TIMEOUT_EN).
REQ-002 SHALL have ports, one per line:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- regwrite, memtoreg, branch, memwrite, memread  in  1 each  control bits from the EX/MEM register.
- addresult  in  16  branch target.
- aluresult  in  16  data address or ALU result.
- regread2  in  16  store data.
- zeroflag  in  1  ALU zero.
- muxout  in  4  destination register.
- mem_req  out  1  data-memory request.
- mem_we  out  1  request is a write.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  write data.
- mem_rdata  in  16  read data.
- mem_ack  in  1  memory completion.
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM (drives their wen low).
- pcsrc  out  1  take branch.
- branch_target  out  16  next PC when pcsrc is high.
- wb_wen  out  1  MEM/WB write enable.
- wb_regwrite, wb_memtoreg  out  1 each  forwarded to MEM/WB.
- wb_readdata  out  16  loaded data.
- wb_aluresult  out  16  ALU result, forwarded.
- wb_dest  out  4  destination register, forwarded.
- mem_err  out  1  sticky timeout flag.

Function
REQ-003 SHALL implement FSM states IDLE, WAIT, DONE; access = memread | memwrite.
REQ-004 IDLE: access=1 -> WAIT next edge; access=0 -> stay IDLE.
REQ-005 WAIT: mem_ack=1 -> DONE; otherwise stay WAIT.
REQ-006 DONE -> IDLE unconditionally after one cycle.
REQ-007 mem_req SHALL be (IDLE & access) | WAIT, combinational.
REQ-008 mem_we SHALL equal memwrite while mem_req=1; otherwise 0.
REQ-009 mem_addr SHALL equal aluresult and mem_wdata SHALL equal regread2 at all times.
REQ-010 mem_req SHALL be held stable from IDLE until ack, because EX/MEM is frozen by stall.
REQ-011 stall SHALL be access & (state != DONE); non-memory instructions SHALL incur zero stall.
REQ-012 A load SHALL capture mem_rdata into rdata_q on the edge where WAIT sees mem_ack.
REQ-013 A store SHALL NOT update rdata_q.
REQ-014 wb_readdata SHALL equal rdata_q.
REQ-015 Minimum memory-instruction latency: 3 cycles (IDLE, WAIT with ack, DONE); stall high for 2 of them.
REQ-016 If memread and memwrite are both 1, the access SHALL be treated as a write (mem_we=1, no capture).
REQ-017 mem_ack outside WAIT SHALL be ignored.
REQ-018 wb_wen SHALL be !stall.
REQ-019 wb_regwrite, wb_memtoreg, wb_aluresult and wb_dest SHALL pass regwrite, memtoreg, aluresult and muxout combinationally.
REQ-020 pcsrc SHALL be branch & zeroflag & !stall; branch_target SHALL equal addresult.

Reset
REQ-021 rst high SHALL immediately force state IDLE, rdata_q=0, mem_err=0 and timeout counter=0.
REQ-022 While rst is high, mem_req, stall and pcsrc SHALL be 0.
REQ-023 Reset during WAIT SHALL abandon the access; a later mem_ack SHALL be ignored.

Configuration
REQ-024 Feature macro MEM_TIMEOUT_EN.
- When defined: a 4-bit counter SHALL count WAIT cycles, cleared on entering WAIT. At TIMEOUT_CYCLES without ack, the FSM SHALL go to DONE, rdata_q SHALL load 16'hDEAD, and mem_err SHALL set and stay set until rst.
- When undefined: WAIT SHALL persist indefinitely, no counter SHALL exist, and mem_err SHALL be tied 0.

Structure
REQ-025 Shared package cpu_pkg SHALL hold:
- FSM state typedef (IDLE=2'd0, WAIT=2'd1, DONE=2'd2);
- DATA_W=16 and REG_W=4;
- TIMEOUT_DEFAULT=15;
- ERR_DATA=16'hDEAD.
REQ-026 The FSM plus timeout counter SHALL be a single sub-module mem_ctrl_fsm; datapath and gating remain in mem_stage.

Verification
REQ-027 ALU op (memread=memwrite=0, aluresult=16'h1234, muxout=4'h3) -> stall=0, wb_wen=1, wb_aluresult=16'h1234, wb_dest=4'h3, same cycle.
REQ-028 Load addr 16'h0040, ack on first WAIT cycle with mem_rdata=16'hBEEF -> mem_req high for 2 cycles, stall high for 2 cycles, wb_readdata=16'hBEEF in DONE.
REQ-029 Store addr 16'h0010, data 16'h5555, ack after 4 WAIT cycles -> mem_we=1 throughout, stall high for 5 cycles, rdata_q unchanged.
REQ-030 branch=1, zeroflag=1, addresult=16'h0100, no access -> pcsrc=1, branch_target=16'h0100; same with zeroflag=0 -> pcsrc=0.
REQ-031 rst asserted mid-WAIT, then ack pulsed -> mem_req and stall drop asynchronously, state stays IDLE, wb_readdata=0.
REQ-032 With MEM_TIMEOUT_EN and no ack for 15 cycles -> DONE, wb_readdata=16'hDEAD, mem_err=1 until rst.
